// File: rtl/button_led_shifter_pkg.sv
// Shared constants for the button-driven LED pattern shifter.
// Mode encoding and the 10 ms debounce window at 100 MHz.
package button_led_shifter_pkg;

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_SAT    = 1'b1;

  localparam int DB_CYCLES_10MS = 1000000;

endpackage

// File: rtl/button_led_shifter_debounce.sv
// Two-flop synchroniser, stable-level debouncer and
// one-cycle registered pulse on each accepted press.
module btn_debounce
  import button_led_shifter_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_10MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_pulse
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] C_MAX = CW'(DB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_st;
  logic          r_st_d;
  logic          r_pulse;
  logic [CW-1:0] r_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_st    <= 1'b0;
      r_st_d  <= 1'b0;
      r_pulse <= 1'b0;
      r_c     <= '0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_st_d  <= r_st;
      r_pulse <= r_st & ~r_st_d;
      if (r_s2 == r_st) begin
        r_c <= '0;
      end else if (r_c == C_MAX) begin
        r_st <= r_s2;
        r_c  <= '0;
      end else begin
        r_c <= r_c + 1'b1;
      end
    end
  end

  assign o_level = r_st;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/button_led_shifter.sv
// Moves an LED pattern left/right on debounced presses,
// rotating or saturating, and counts moves that changed it.
module button_led_shifter
  import button_led_shifter_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] INIT      = WIDTH'(1),
  parameter int               DB_CYCLES = DB_CYCLES_10MS,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             mode_sat,
  output logic [WIDTH-1:0] led,
  output logic [1:0]       btn_db,
  output logic [CNT_W-1:0] move_cnt,
  output logic             at_edge
);

  logic             w_db_l;
  logic             w_db_r;
  logic             w_pl;
  logic             w_pr;
  logic             w_sat;
  logic [WIDTH-1:0] w_next;

  logic             r_m1;
  logic             r_m2;
  logic [WIDTH-1:0] r_led;
  logic [CNT_W-1:0] r_cnt;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (btn_left),
    .o_level (w_db_l),
    .o_pulse (w_pl)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (btn_right),
    .o_level (w_db_r),
    .o_pulse (w_pr)
  );

  assign w_sat = (r_m2 == MODE_SAT);

  // Simultaneous presses cancel out.
  always_comb begin
    w_next = r_led;
    unique case (1'b1)
      (w_pl & ~w_pr): begin
        if (w_sat)
          w_next = r_led[WIDTH-1] ? r_led : (r_led << 1);
        else
          w_next = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
      end
      (w_pr & ~w_pl): begin
        if (w_sat)
          w_next = r_led[0] ? r_led : (r_led >> 1);
        else
          w_next = {r_led[0], r_led[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m1  <= 1'b0;
      r_m2  <= 1'b0;
      r_led <= INIT;
      r_cnt <= '0;
    end else begin
      r_m1  <= mode_sat;
      r_m2  <= r_m1;
      r_led <= w_next;
      if (w_next != r_led)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign led      = r_led;
  assign btn_db   = {w_db_r, w_db_l};
  assign move_cnt = r_cnt;
  assign at_edge  = r_led[WIDTH-1] | r_led[0];

endmodule

// File: tb/tb_button_led_shifter.sv
// Directed bench for button_led_shifter with WIDTH=8,
// INIT=01, DB_CYCLES=4.
module tb_button_led_shifter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       mode_sat = 1'b0;
  logic [7:0] led;
  logic [1:0] btn_db;
  logic [7:0] move_cnt;
  logic       at_edge;

  int n_chk = 0;
  int n_fail = 0;

  button_led_shifter #(
    .WIDTH     (8),
    .INIT      (8'h01),
    .DB_CYCLES (4),
    .CNT_W     (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .mode_sat  (mode_sat),
    .led       (led),
    .btn_db    (btn_db),
    .move_cnt  (move_cnt),
    .at_edge   (at_edge)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, land 1 time unit after the last.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_l();
    btn_left = 1'b1;
    tick(10);
    btn_left = 1'b0;
    tick(10);
  endtask

  task automatic press_r();
    btn_right = 1'b1;
    tick(10);
    btn_right = 1'b0;
    tick(10);
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst_led", led, 8'h01);
    check("rst_db", btn_db, 2'b00);
    check("rst_cnt", move_cnt, 8'd0);
    check("rst_edge", at_edge, 1'b1);

    // Hold left: first sampled at E0.
    btn_left = 1'b1;
    tick(5);
    check("db_pre_E5", btn_db, 2'b00);
    tick(1);
    check("db_E5", btn_db, 2'b01);
    tick(1);
    check("led_E6", led, 8'h01);
    tick(1);
    check("led_E7", led, 8'h02);
    check("cnt_E7", move_cnt, 8'd1);
    tick(20);
    check("held_led", led, 8'h02);
    check("held_cnt", move_cnt, 8'd1);
    btn_left = 1'b0;
    tick(10);
    check("rel_db", btn_db, 2'b00);
    check("rel_led", led, 8'h02);

    // Three-cycle glitch is rejected.
    btn_left = 1'b1;
    tick(3);
    btn_left = 1'b0;
    tick(15);
    check("gl_db", btn_db, 2'b00);
    check("gl_led", led, 8'h02);
    check("gl_cnt", move_cnt, 8'd1);

    repeat (6) press_l();
    check("walk_led", led, 8'h80);
    check("walk_edge", at_edge, 1'b1);
    check("walk_cnt", move_cnt, 8'd7);
    press_l();
    check("rot_l_led", led, 8'h01);
    check("rot_l_cnt", move_cnt, 8'd8);
    press_r();
    check("rot_r_led", led, 8'h80);
    check("rot_r_cnt", move_cnt, 8'd9);

    mode_sat = 1'b1;
    tick(4);
    check("mode_led", led, 8'h80);
    press_l();
    check("sat_led", led, 8'h80);
    check("sat_cnt", move_cnt, 8'd9);
    check("sat_edge", at_edge, 1'b1);

    // Both together cancel; then right alone moves.
    btn_left = 1'b1;
    btn_right = 1'b1;
    tick(12);
    check("both_db", btn_db, 2'b11);
    check("both_led", led, 8'h80);
    check("both_cnt", move_cnt, 8'd9);
    btn_right = 1'b0;
    tick(10);
    check("both_rdb", btn_db, 2'b01);
    btn_right = 1'b1;
    tick(10);
    check("re_r_led", led, 8'h40);
    check("re_r_cnt", move_cnt, 8'd10);
    check("re_r_edge", at_edge, 1'b0);
    btn_left = 1'b0;
    btn_right = 1'b0;
    tick(10);

    mode_sat = 1'b0;
    tick(4);
    repeat (4) press_r();
    check("pre_rst_led", led, 8'h04);
    check("pre_rst_cnt", move_cnt, 8'd14);

    // Reset while right counter is mid-count.
    btn_right = 1'b1;
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_led", led, 8'h01);
    check("arst_cnt", move_cnt, 8'd0);
    check("arst_db", btn_db, 2'b00);
    tick(3);
    #2;
    rst_n = 1'b1;
    tick(5);
    check("post_db_early", btn_db, 2'b00);
    tick(10);
    check("post_led", led, 8'h80);
    check("post_cnt", move_cnt, 8'd1);
    tick(20);
    check("post_hold_led", led, 8'h80);
    check("post_hold_cnt", move_cnt, 8'd1);
    btn_right = 1'b0;
    tick(10);

    // 254 more left rotates -> 255, one more wraps.
    repeat (254) press_l();
    check("cnt_255", move_cnt, 8'd255);
    press_l();
    check("cnt_wrap", move_cnt, 8'd0);
    check("wrap_led", led, 8'h40);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
